ah_credit_sender: RTL and testbench
===================================

// Module: ah_credit_sender
// PURPOSE
//  Transmit end of the credit-based valid/credit write interface used by the AH snoopable FIFOs.
//  - Accepts items from a local valid/ready producer into a 2-entry skid buffer.
//  - Drives wr_data/wr_valid toward the receiving FIFO.
//  - Tracks the receiver's free entries with a credit counter that wr_credit replenishes.
//  - Never issues wr_valid without a credit in hand.
// PARAMETERS
//  DATA_W    8   width of data items
//  CREDITS   10  initial credit count; equals receiving FIFO depth, must be >=1
//  CREDIT_W  4   credit counter width; 2**CREDIT_W > CREDITS
// PORTS
//  clk          in   1         clock; all logic on posedge
//  rstn         in   1         asynchronous active-low reset
//  in_data      in   DATA_W    producer data
//  in_valid     in   1         producer item valid
//  in_ready     out  1         buffer can accept; registered
//  wr_data      out  DATA_W    data to receiver; registered
//  wr_valid     out  1         one-cycle pulse = one item sent, consumes one credit
//  wr_credit    in   1         one-cycle pulse = receiver freed one entry, returns one credit
//  credit_cnt   out  CREDIT_W  current credits held
//  credit_err   out  1         sticky: credit returned while credit_cnt==CREDITS
//  idle         out  1         buffer empty and credit_cnt==CREDITS
//  snoop_data   out  DATA_W    head item presented for snoop
//  snoop_valid  out  1         snoop request valid
//  snoop_match  in   1         receiver reports head item already queued; same cycle as snoop_valid
// BEHAVIOUR
//  Reset values (async on rstn low):
//   - in_ready=0, wr_valid=0, wr_data=0, credit_cnt=CREDITS, credit_err=0, idle=1
//   - snoop_valid=0, snoop_data=0, buffer empty, FSM=INIT
//  FSM states and transitions:
//   - INIT: exactly one cycle after rstn deasserts; in_ready rises at its end; -> IDLE.
//   - IDLE: buffer empty. Item accepted -> HEAD.
//   - HEAD: head item waiting.
//      - credit_cnt>0 -> SEND.
//      - credit_cnt==0 -> WAIT.
//   - WAIT: head held, no credit; wr_credit pulse -> SEND on the next cycle.
//   - SEND: wr_valid=1 for one cycle with wr_data=head; pop head.
//      - Buffer still non-empty -> HEAD.
//      - Buffer empty -> IDLE.
//  Handshake and latency:
//   - Input transfer occurs when in_valid&&in_ready.
//   - in_ready=(occupancy<2) after the registered update.
//   - A producer that ignores in_ready loses data (not checked).
//   - Accept at cycle N -> earliest wr_valid at N+2 (HEAD at N+1, SEND at N+2).
//   - Back-to-back SEND with continuous credits yields one item every 2 cycles.
//  Credit arithmetic (one update per cycle):
//   - credit_cnt_next = credit_cnt - (wr_valid issued) + wr_credit.
//   - wr_valid and wr_credit in the same cycle -> count unchanged.
//   - wr_credit at credit_cnt==CREDITS with no send -> count saturates at CREDITS, credit_err set until reset.
//   - credit_cnt never wraps below 0: SEND is entered only with credit_cnt>0.
//  Buffer boundaries:
//   - Push and pop in the same cycle with occupancy 2 -> push permitted; in_ready stays 1.
//   - Buffer order is strict FIFO.
//  Reset mid-operation:
//   - Buffered items are discarded.
//   - Credits reload to CREDITS; the receiver is reset by the same rstn.
//  idle is registered and reflects the state after the current update.
// CONFIGURATION
//  AH_SENDER_SNOOP_EN defined:
//   - Extra FSM state SNOOP inserted between HEAD and SEND.
//   - SNOOP asserts snoop_valid=1 with snoop_data=head for one cycle and samples snoop_match.
//   - match=1: head dropped, no wr_valid, no credit consumed; -> HEAD or IDLE.
//   - match=0: -> SEND, or WAIT if credit_cnt==0.
//   - Latency accept->wr_valid becomes N+3.
//  Not defined:
//   - SNOOP state absent; snoop_valid=0 and snoop_data=0 constantly; snoop_match ignored.
// TESTING
//  1. Reset release, in_valid=1 data 8'hA5 at first ready cycle N
//     -> wr_valid pulse with 8'hA5 at N+2; credit_cnt 10->9.
//  2. Stream 12 items with wr_credit tied 0
//     -> exactly 10 wr_valid pulses; credit_cnt=0; FSM in WAIT; in_ready=0 once buffer holds 2.
//     Then one wr_credit pulse -> 11th item sent, credit_cnt returns to 0.
//  3. wr_valid and wr_credit in the same cycle at credit_cnt=5 -> credit_cnt stays 5.
//  4. wr_credit pulse while idle (credit_cnt=10) -> credit_cnt stays 10, credit_err=1 until rstn.
//  5. rstn low for 1 cycle with 2 items buffered and credit_cnt=3
//     -> no further wr_valid; credit_cnt=10; idle=1.
//  6. AH_SENDER_SNOOP_EN: item 8'h3C with snoop_match=1 in its SNOOP cycle
//     -> snoop_valid/snoop_data=8'h3C seen, no wr_valid, credit_cnt unchanged.
//     Next item 8'h3D with match=0 -> sent at accept+3.

Source files
------------

// File: rtl/ah_credit_sender.sv
// Transmit end of the AH credit-based write interface: a 2-entry skid buffer, a credit counter and a send FSM.
// Optional snoop stage before each send is enabled by defining AH_SENDER_SNOOP_EN.
module ah_credit_sender #(
    parameter int DATA_W   = 8,
    parameter int CREDITS  = 10,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_valid,
    input  logic                wr_credit,
    output logic [CREDIT_W-1:0] credit_cnt,
    output logic                credit_err,
    output logic                idle,
    output logic [DATA_W-1:0]   snoop_data,
    output logic                snoop_valid,
    input  logic                snoop_match
);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_HEAD, ST_WAIT, ST_SEND, ST_SNOOP} state_e;

    state_e                   state_q, state_d;
    logic [1:0][DATA_W-1:0]   buf_q, buf_d;
    logic [1:0]               occ_q, occ_d, occ_kept;
    logic [CREDIT_W-1:0]      cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     in_ready_q, in_ready_d;
    logic                     wr_valid_q, wr_valid_d;
    logic [DATA_W-1:0]        wr_data_q, wr_data_d;
    logic                     idle_q, idle_d;
    logic                     push, sending, pop, drop;

`ifdef AH_SENDER_SNOOP_EN
    assign drop = (state_q == ST_SNOOP) && snoop_match;
`else
    logic unused_snoop_match;
    assign unused_snoop_match = snoop_match;
    assign drop               = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
        push     = in_valid && in_ready_q;
        sending  = (state_q == ST_SEND);
        pop      = sending || drop;

        // Head always lives in entry 0; a pop shifts entry 1 forward before the push lands.
        buf_d    = buf_q;
        occ_kept = occ_q - {1'b0, pop};
        if (pop)
            buf_d[0] = buf_q[1];
        if (push) begin
            if (occ_kept == 2'd0)
                buf_d[0] = in_data;
            else
                buf_d[1] = in_data;
        end
        occ_d = occ_kept + {1'b0, push};

        cnt_d = cnt_q;
        err_d = err_q;
        if (sending && !wr_credit)
            cnt_d = cnt_q - CREDIT_W'(1);
        else if (!sending && wr_credit) begin
            if (cnt_q == CREDIT_MAX)
                err_d = 1'b1;
            else
                cnt_d = cnt_q + CREDIT_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: if (push) state_d = ST_HEAD;
`ifdef AH_SENDER_SNOOP_EN
            ST_HEAD: state_d = ST_SNOOP;
            ST_SNOOP: begin
                if (snoop_match)
                    state_d = (occ_d != 2'd0) ? ST_HEAD : ST_IDLE;
                else
                    state_d = (cnt_q != '0) ? ST_SEND : ST_WAIT;
            end
`else
            ST_HEAD: state_d = (cnt_q != '0) ? ST_SEND : ST_WAIT;
`endif
            // Leaving on the updated count also covers a credit that arrived on the cycle WAIT was entered.
            ST_WAIT: if (cnt_d != '0) state_d = ST_SEND;
            ST_SEND: state_d = (occ_d != 2'd0) ? ST_HEAD : ST_IDLE;
            default: state_d = ST_INIT;
        endcase

        wr_valid_d = (state_d == ST_SEND);
        wr_data_d  = wr_valid_d ? buf_d[0] : wr_data_q;
        // A pop already scheduled for next cycle frees a slot, so a full buffer may still take a push.
        in_ready_d = (occ_d < 2'd2) || wr_valid_d;
        idle_d     = (occ_d == 2'd0) && (cnt_d == CREDIT_MAX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_INIT;
            occ_q      <= 2'd0;
            cnt_q      <= CREDIT_MAX;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            idle_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every register sample the pre-edge values of the others.
            state_q    <= state_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            idle_q     <= idle_d;
        end
    end

    // NOTE: buffer storage is deliberately not reset; occ_q alone says which entries hold live data.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

`ifdef AH_SENDER_SNOOP_EN
    logic              snoop_valid_q, snoop_valid_d;
    logic [DATA_W-1:0] snoop_data_q, snoop_data_d;

    always_comb begin
        snoop_valid_d = (state_d == ST_SNOOP);
        snoop_data_d  = snoop_valid_d ? buf_d[0] : snoop_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snoop_valid_q <= 1'b0;
            snoop_data_q  <= '0;
        end else begin
            snoop_valid_q <= snoop_valid_d;
            snoop_data_q  <= snoop_data_d;
        end
    end

    assign snoop_valid = snoop_valid_q;
    assign snoop_data  = snoop_data_q;
`else
    assign snoop_valid = 1'b0;
    assign snoop_data  = '0;
`endif

    assign in_ready   = in_ready_q;
    assign wr_valid   = wr_valid_q;
    assign wr_data    = wr_data_q;
    assign credit_cnt = cnt_q;
    assign credit_err = err_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_ah_credit_sender.sv
// Self-checking bench for ah_credit_sender (default build): directed scenarios plus random traffic,
// with a queue-based reference model checked on every falling edge.
module tb_ah_credit_sender;
    localparam int CREDITS = 10;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_credit;
    logic [3:0] credit_cnt;
    logic       credit_err;
    logic       idle;
    logic [7:0] snoop_data;
    logic       snoop_valid;
    logic       snoop_match;

    int n_cmp  = 0;
    int n_fail = 0;

    ah_credit_sender #(.DATA_W(8), .CREDITS(CREDITS), .CREDIT_W(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_credit   (wr_credit),
        .credit_cnt  (credit_cnt),
        .credit_err  (credit_err),
        .idle        (idle),
        .snoop_data  (snoop_data),
        .snoop_valid (snoop_valid),
        .snoop_match (snoop_match)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a queue, credits are plain integers, and the head item's
    // progress is tracked as a phase (just arrived, waiting for credit, on the wire).
    localparam int P_INIT = 0, P_EMPTY = 1, P_HEAD = 2, P_WAIT = 3, P_SEND = 4;
    logic [7:0] mq[$];
    int         m_cnt, m_phase, m_next, cnt_next;
    bit         m_err, m_rdy, m_wv, m_idle, sending, took;
    logic [7:0] m_wd;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_cnt = CREDITS; m_phase = P_INIT; m_err = 1'b0;
            m_rdy = 1'b0; m_wv = 1'b0; m_wd = 8'h00; m_idle = 1'b1;
        end else begin
            sending  = (m_phase == P_SEND);
            took     = in_valid && m_rdy;
            cnt_next = m_cnt - int'(sending) + int'(wr_credit);
            if (cnt_next > CREDITS) begin
                cnt_next = CREDITS;
                m_err    = 1'b1;
            end
            if (sending) void'(mq.pop_front());
            if (took) mq.push_back(in_data);
            case (m_phase)
                P_INIT:  m_next = P_EMPTY;
                P_EMPTY: m_next = (mq.size() > 0) ? P_HEAD : P_EMPTY;
                P_HEAD:  m_next = (m_cnt > 0) ? P_SEND : P_WAIT;
                P_WAIT:  m_next = (cnt_next > 0) ? P_SEND : P_WAIT;
                default: m_next = (mq.size() > 0) ? P_HEAD : P_EMPTY;
            endcase
            m_phase = m_next;
            m_cnt   = cnt_next;
            m_wv    = (m_phase == P_SEND);
            if (m_wv) m_wd = mq[0];
            m_rdy   = (mq.size() < 2) || m_wv;
            m_idle  = (mq.size() == 0) && (m_cnt == CREDITS);
        end
    end

    always @(negedge clk) begin
        check("in_ready",    32'(in_ready),    32'(m_rdy));
        check("wr_valid",    32'(wr_valid),    32'(m_wv));
        if (m_wv) check("wr_data", 32'(wr_data), 32'(m_wd));
        check("credit_cnt",  32'(credit_cnt),  32'(m_cnt));
        check("credit_err",  32'(credit_err),  32'(m_err));
        check("idle",        32'(idle),        32'(m_idle));
        check("snoop_valid", 32'(snoop_valid), 32'd0);
        check("snoop_data",  32'(snoop_data),  32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; in_valid = 1'b0; wr_credit = 1'b0;
        step(); step();
        rstn = 1'b1;
        step();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic push_and_wait_send(input logic [7:0] d);
        int n = 0;
        wait_ready();
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
        while (!wr_valid && n < 10) begin step(); n++; end
        check("wr_valid_timeout", 32'(wr_valid), 32'd1);
    endtask

    initial begin
        int idx, pulses, outstanding;
        logic rdy_before;
        rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; wr_credit = 1'b0; snoop_match = 1'b0;
        step(); step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_credit",   32'(credit_cnt), 32'd10);
        check("rst_idle",     32'(idle), 32'd1);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);

        // First ready cycle after INIT, then accept 0xA5 and see it two cycles later.
        rstn = 1'b1;
        step();
        check("t1_ready_after_init", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        check("t1_no_send_n1", 32'(wr_valid), 32'd0);
        step();
        check("t1_send_n2",  32'(wr_valid), 32'd1);
        check("t1_data_n2",  32'(wr_data), 32'hA5);
        step();
        check("t1_credit_9", 32'(credit_cnt), 32'd9);

        // Twelve items, no returns: ten go out, then the sender stalls with a full buffer.
        do_reset();
        idx = 0; pulses = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid   = (idx < 12);
            in_data    = 8'(8'h10 + idx);
            rdy_before = in_ready;
            step();
            if (in_valid && rdy_before) idx++;
            if (wr_valid) pulses++;
        end
        in_valid = 1'b0;
        check("t2_accepted",  32'(idx), 32'd12);
        check("t2_pulses_10", 32'(pulses), 32'd10);
        check("t2_credit_0",  32'(credit_cnt), 32'd0);
        check("t2_not_ready", 32'(in_ready), 32'd0);
        wr_credit = 1'b1;
        step();
        wr_credit = 1'b0;
        if (wr_valid) pulses++;
        for (int c = 0; c < 6; c++) begin
            step();
            if (wr_valid) pulses++;
        end
        check("t2_pulses_11",   32'(pulses), 32'd11);
        check("t2_credit_back", 32'(credit_cnt), 32'd0);

        // Send and return in the same cycle at five credits.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_and_wait_send(8'(8'h40 + i));
            step();
        end
        check("t3_credit_5", 32'(credit_cnt), 32'd5);
        push_and_wait_send(8'h66);
        wr_credit = 1'b1;
        step();
        wr_credit = 1'b0;
        check("t3_credit_held", 32'(credit_cnt), 32'd5);

        // Spurious return while idle saturates and sets the sticky error.
        do_reset();
        wr_credit = 1'b1;
        step();
        wr_credit = 1'b0;
        check("t4_credit_sat", 32'(credit_cnt), 32'd10);
        check("t4_err_set",    32'(credit_err), 32'd1);
        step(); step(); step();
        check("t4_err_sticky", 32'(credit_err), 32'd1);
        do_reset();
        check("t4_err_cleared", 32'(credit_err), 32'd0);

        // Reset with two items buffered and three credits left.
        for (int i = 0; i < 6; i++) begin
            push_and_wait_send(8'(8'h70 + i));
            step();
        end
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = 8'(8'h80 + c);
            step();
            if (wr_valid) break;
        end
        check("t5_streaming_send", 32'(wr_valid), 32'd1);
        in_data = 8'h90;
        step();
        in_valid = 1'b0;
        check("t5_credit_3",  32'(credit_cnt), 32'd3);
        check("t5_buf_full",  32'(in_ready), 32'd0);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (wr_valid) pulses++;
        end
        check("t5_no_send",     32'(pulses), 32'd0);
        check("t5_credit_10",   32'(credit_cnt), 32'd10);
        check("t5_idle",        32'(idle), 32'd1);

        // Random traffic against a receiver that returns credits late, plus rare spurious returns and resets.
        do_reset();
        outstanding = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            wr_credit = (outstanding > 0 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
            if (wr_credit && outstanding > 0) outstanding--;
            if ($urandom_range(0, 499) == 0) begin
                rstn = 1'b0; outstanding = 0;
            end else begin
                rstn = 1'b1;
            end
            step();
            if (wr_valid) outstanding++;
        end
        in_valid = 1'b0; wr_credit = 1'b0; rstn = 1'b1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
